ud_counter_n: RTL

Parametrised synchronous up/down counter. It replaces ripple-clocked JK counter chains with a single-clock, fully registered design. It adds programmable modulus, parallel load, synchronous clear, wrap-or-saturate mode, terminal-count detection and a sticky overflow flag. Counter datapaths use it wherever a decade, modulo-N or bounded up/down count is needed.

---
 rtl/ud_counter_n.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ud_counter_n.sv
// ud_counter_n: single-clock up/down counter with programmable modulus,
// parallel load, synchronous clear, wrap-or-saturate behaviour,
// combinational terminal count, registered terminal event pulse and a
// sticky overflow/underflow flag.
module ud_counter_n #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] C_MAX  = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Load values above the modulus are pinned to MAX so q never leaves 0..MAX.
  function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    if (value > C_MAX) begin
      result = C_MAX;
    end else begin
      result = value;
    end
    return result;
  endfunction

  logic [WIDTH-1:0] r_q;
  logic             r_evt;
  logic             r_ovf;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_evt_nxt;
  logic             w_ovf_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;
  logic             w_term_step;

  assign w_at_max  = (r_q == C_MAX);
  assign w_at_zero = (r_q == C_ZERO);

  // Terminal count: enabled and sitting on the boundary in the current direction.
  always_comb begin
    w_tc = 1'b0;
    if (en) begin
      if (up) begin
        w_tc = w_at_max;
      end else begin
        w_tc = w_at_zero;
      end
    end else begin
      w_tc = 1'b0;
    end
  end

  // A terminal step is a boundary count that is not overridden by clr or load.
  assign w_term_step = w_tc & ~clr & ~load;

  // Next-count selection with clr > load > en > hold priority.
  always_comb begin
    w_q_nxt = r_q;
    if (clr) begin
      w_q_nxt = C_ZERO;
    end else if (load) begin
      w_q_nxt = clamp_to_max(din);
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
          w_q_nxt = SATURATE ? C_MAX : C_ZERO;
        end else begin
          w_q_nxt = r_q + C_ONE;
        end
      end else begin
        if (w_at_zero) begin
          w_q_nxt = SATURATE ? C_ZERO : C_MAX;
        end else begin
          w_q_nxt = r_q - C_ONE;
        end
      end
    end else begin
      w_q_nxt = r_q;
    end
  end

  // Event pulse follows each terminal step; overflow is sticky until clr.
  always_comb begin
    w_evt_nxt = 1'b0;
    w_ovf_nxt = r_ovf;
    if (clr) begin
      w_evt_nxt = 1'b0;
      w_ovf_nxt = 1'b0;
    end else begin
      w_evt_nxt = w_term_step;
      w_ovf_nxt = r_ovf | w_term_step;
    end
  end

  // State registers with asynchronous clear to the idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= C_ZERO;
      r_evt <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_evt <= w_evt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign q   = r_q;
  assign qb  = ~r_q;
  assign tc  = w_tc;
  assign evt = r_evt;
  assign ovf = r_ovf;

endmodule
